// File: rtl/led_level_pwm.sv
// Saturating brightness level driven by confirmed button presses, with a registered PWM LED output.
// Optional feature LED_AUTO_REPEAT_EN: holding a button (code 3) issues a step every REPEAT_D cycles.
module led_level_pwm #(
  parameter int MAX_LEVEL   = 15,
  parameter int LW          = 4,
  parameter int RESET_LEVEL = 0,
  parameter int PRESCALE    = 1000,
  parameter int REPEAT_D    = 5000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    up_s,
  input  logic [1:0]    down_s,
  output logic [LW-1:0] level,
  output logic          led,
  output logic          sat
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEVEL);
  localparam logic [LW-1:0] RST_L   = LW'(RESET_LEVEL);
  localparam logic [LW-1:0] PCNT_LAST = LW'(MAX_LEVEL - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);

  logic [LW-1:0] level_q, level_d;
  logic          sat_q, sat_d;
  logic          led_q, led_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [LW-1:0] pcnt_q, pcnt_d;
  logic          inc, dec;

`ifdef LED_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_D > 1) ? $clog2(REPEAT_D) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_D - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          hold_one, rpt_fire;

  // Counter runs only while exactly one button is held; a fire restarts it.
  always_comb begin
    hold_one = (up_s == 2'd3) ^ (down_s == 2'd3);
    rpt_fire = hold_one && (rpt_q == RPT_LAST);
    rpt_d    = (!hold_one || rpt_fire) ? '0 : rpt_q + 1'b1;
    inc      = (up_s == 2'd2)   || (rpt_fire && (up_s == 2'd3));
    dec      = (down_s == 2'd2) || (rpt_fire && (down_s == 2'd3));
  end
`else
  localparam int unused_repeat_d = REPEAT_D;

  always_comb begin
    inc = (up_s == 2'd2);
    dec = (down_s == 2'd2);
  end
`endif

  always_comb begin
    level_d = level_q;
    sat_d   = 1'b0;
    if (inc && !dec) begin
      if (level_q == MAX_L) sat_d = 1'b1;
      else                  level_d = level_q + 1'b1;
    end else if (dec && !inc) begin
      if (level_q == '0) sat_d = 1'b1;
      else               level_d = level_q - 1'b1;
    end
  end

  // PWM counters free-run; level changes never disturb them.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    pcnt_d = pcnt_q;
    if (pre_q == PRE_LAST) pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
    led_d  = (level_q > pcnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= RST_L;
      sat_q   <= 1'b0;
      led_q   <= 1'b0;
      pre_q   <= '0;
      pcnt_q  <= '0;
`ifdef LED_AUTO_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      level_q <= level_d;
      sat_q   <= sat_d;
      led_q   <= led_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
`ifdef LED_AUTO_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign level = level_q;
  assign led   = led_q;
  assign sat   = sat_q;

endmodule
